// File: rtl/gelato_ibuffer_mq.sv
// Per-warp circular instruction queues between decode and issue, with round-robin issue pick.
// In->out latency 1 cycle (no bypass); in_ready drops on full/flushed warp, out grant locks while stalled.
package gelato_ibuf_pkg;
  typedef struct packed {
    logic [7:0] opcode;
    logic [5:0] rd;
    logic [5:0] rs1;
    logic [5:0] rs2;
    logic [5:0] imm;
  } inst_t;
endpackage

module gelato_ibuffer_mq
  import gelato_ibuf_pkg::*;
#(
  parameter int NUM_WARPS  = 4,
  parameter int DEPTH      = 4,
  parameter int INST_WIDTH = $bits(inst_t),
  parameter int WARP_ID_W  = $clog2(NUM_WARPS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WARP_ID_W-1:0]  in_warp_id,
  input  logic [INST_WIDTH-1:0] in_inst,
  input  logic [NUM_WARPS-1:0]  flush_mask,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WARP_ID_W-1:0]  out_warp_id,
  output logic [INST_WIDTH-1:0] out_inst,
  output logic [NUM_WARPS-1:0]  full_mask,
  output logic [NUM_WARPS-1:0]  empty_mask
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0]         r_wr_ptr [NUM_WARPS];
  logic [PW-1:0]         r_rd_ptr [NUM_WARPS];
  logic [INST_WIDTH-1:0] r_mem    [NUM_WARPS][DEPTH];
  logic [WARP_ID_W-1:0]  r_rr_ptr;
  logic [WARP_ID_W-1:0]  r_grant;
  logic                  r_lock;

  logic [NUM_WARPS-1:0]  w_full;
  logic [NUM_WARPS-1:0]  w_empty;
  logic [NUM_WARPS-1:0]  w_elig;
  logic [WARP_ID_W-1:0]  w_rr_grant;
  logic                  w_rr_hit;
  logic [WARP_ID_W-1:0]  w_grant;
  logic                  w_push;
  logic                  w_pop;
  int                    w_idx;

  // MSB of each pointer is the wrap bit: equal index with differing wrap means full.
  always_comb begin
    w_full  = '0;
    w_empty = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      w_empty[w] = (r_rd_ptr[w] == r_wr_ptr[w]);
      w_full[w]  = (r_rd_ptr[w][IW-1:0] == r_wr_ptr[w][IW-1:0]) &&
                   (r_rd_ptr[w][IW] != r_wr_ptr[w][IW]);
    end
  end

  assign w_elig     = ~w_empty & ~flush_mask;
  assign full_mask  = w_full;
  assign empty_mask = w_empty;
  assign in_ready   = !w_full[in_warp_id] && !flush_mask[in_warp_id];
  assign w_push     = in_valid && in_ready;

  // Descending scan so the last hit is the nearest eligible warp at or after r_rr_ptr.
  always_comb begin
    w_rr_grant = r_rr_ptr;
    w_rr_hit   = 1'b0;
    w_idx      = 0;
    for (int k = NUM_WARPS - 1; k >= 0; k--) begin
      w_idx = (int'(r_rr_ptr) + k) % NUM_WARPS;
      if (w_elig[w_idx]) begin
        w_rr_grant = WARP_ID_W'(w_idx);
        w_rr_hit   = 1'b1;
      end
    end
  end

  assign w_grant     = r_lock ? r_grant : w_rr_grant;
  assign out_valid   = r_lock ? w_elig[r_grant] : w_rr_hit;
  assign out_warp_id = w_grant;
  assign out_inst    = r_mem[w_grant][r_rd_ptr[w_grant][IW-1:0]];
  assign w_pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        r_wr_ptr[w] <= '0;
        r_rd_ptr[w] <= '0;
      end
      r_rr_ptr <= '0;
      r_grant  <= '0;
      r_lock   <= 1'b0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (flush_mask[w])
          r_rd_ptr[w] <= r_wr_ptr[w];
        else if (w_pop && (w_grant == WARP_ID_W'(w)))
          r_rd_ptr[w] <= r_rd_ptr[w] + 1'b1;
        if (w_push && (in_warp_id == WARP_ID_W'(w)))
          r_wr_ptr[w] <= r_wr_ptr[w] + 1'b1;
      end
      if (w_pop)
        r_rr_ptr <= (w_grant == WARP_ID_W'(NUM_WARPS - 1)) ? '0 : w_grant + 1'b1;
      // A stalled offer freezes the grant; a flush of that warp drops out_valid and so the lock.
      r_lock  <= out_valid && !out_ready;
      r_grant <= w_grant;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[in_warp_id][r_wr_ptr[in_warp_id][IW-1:0]] <= in_inst;
  end

endmodule

// File: tb/tb_gelato_ibuffer_mq.sv
// Bench for gelato_ibuffer_mq: directed scenarios plus random traffic against a queue-based model.
module tb_gelato_ibuffer_mq;
  localparam int NW = 4;
  localparam int DP = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_warp_id;
  logic [31:0] in_inst;
  logic [3:0]  flush_mask;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_warp_id;
  logic [31:0] out_inst;
  logic [3:0]  full_mask;
  logic [3:0]  empty_mask;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mq [NW][$];
  int          m_rr = 0;
  bit          m_lock = 0;
  int          m_lockw = 0;

  gelato_ibuffer_mq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_warp_id(in_warp_id), .in_inst(in_inst),
    .flush_mask(flush_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_warp_id(out_warp_id), .out_inst(out_inst),
    .full_mask(full_mask), .empty_mask(empty_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; leaves at the next posedge+1.
  task automatic do_reset();
    in_valid   = 1'b0;
    flush_mask = '0;
    out_ready  = 1'b0;
    in_warp_id = 2'd3;
    rst_n      = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_full", full_mask, 4'h0);
    chk("rst_empty", empty_mask, 4'hF);
    chk("rst_warp_id", out_warp_id, 0);
    for (int w = 0; w < NW; w++) mq[w].delete();
    m_rr = 0;
    m_lock = 0;
    m_lockw = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One clock of stimulus: checks DUT against the model mid-cycle, then advances the model.
  task automatic cyc(input bit iv, input int iw, input logic [31:0] d, input logic [3:0] fl,
                     input bit ordy);
    bit       elig [NW];
    bit       ev;
    int       eg;
    bit       eir;
    logic [3:0] ef;
    logic [3:0] ee;
    in_valid   = iv;
    in_warp_id = 2'(iw);
    in_inst    = d;
    flush_mask = fl;
    out_ready  = ordy;
    #4;
    ef = '0;
    ee = '0;
    for (int w = 0; w < NW; w++) begin
      ef[w]   = (mq[w].size() == DP);
      ee[w]   = (mq[w].size() == 0);
      elig[w] = (mq[w].size() > 0) && !fl[w];
    end
    eir = !ef[iw] && !fl[iw];
    if (m_lock) begin
      eg = m_lockw;
      ev = elig[eg];
    end else begin
      ev = 0;
      eg = m_rr;
      for (int k = 0; k < NW; k++) begin
        if (!ev && elig[(m_rr + k) % NW]) begin
          ev = 1;
          eg = (m_rr + k) % NW;
        end
      end
    end
    chk("in_ready", in_ready, eir);
    chk("out_valid", out_valid, ev);
    if (ev) begin
      chk("out_warp_id", out_warp_id, eg);
      chk("out_inst", out_inst, mq[eg][0]);
    end
    chk("full_mask", full_mask, ef);
    chk("empty_mask", empty_mask, ee);
    @(posedge clk);
    for (int w = 0; w < NW; w++) if (fl[w]) mq[w].delete();
    if (ev && ordy) begin
      void'(mq[eg].pop_front());
      m_rr = (eg + 1) % NW;
      m_lock = 0;
    end else begin
      m_lock = ev;
      m_lockw = eg;
    end
    if (iv && eir) mq[iw].push_back(d);
    #1;
  endtask

  initial begin
    logic [1:0] ord [6];
    ord = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    rst_n = 1'b0;
    in_valid = 1'b0; in_warp_id = '0; in_inst = '0; flush_mask = '0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Single push reaches the output one cycle later
    cyc(1, 2, 32'hA5, 4'h0, 0);
    chk("t1_valid", out_valid, 1);
    chk("t1_warp", out_warp_id, 2);
    chk("t1_inst", out_inst, 32'hA5);
    chk("t1_empty", empty_mask, 4'b1011);

    // Fill warp 0, then pop+push same cycle: push refused
    do_reset();
    for (int i = 0; i < DP; i++) cyc(1, 0, 32'h100 + i, 4'h0, 0);
    chk("t2_full", full_mask, 4'b0001);
    in_valid = 1'b1; in_warp_id = 2'd0;
    #1;
    chk("t2_in_ready", in_ready, 0);
    cyc(1, 0, 32'h1FF, 4'h0, 1);
    chk("t2_notfull", full_mask, 4'b0000);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 4'h0, 1);
    chk("t2_drained", empty_mask, 4'hF);

    // Round-robin issue across warps 0,1,3
    do_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, 32'h200 + i, 4'h0, 0);
      cyc(1, 1, 32'h210 + i, 4'h0, 0);
      cyc(1, 3, 32'h230 + i, 4'h0, 0);
    end
    for (int i = 0; i < 6; i++) begin
      chk("t3_order", out_warp_id, ord[i]);
      cyc(0, 0, 0, 4'h0, 1);
    end

    // Grant held on warp 1 while stalled even after warp 0 arrives
    do_reset();
    cyc(1, 1, 32'h301, 4'h0, 0);
    cyc(1, 0, 32'h300, 4'h0, 0);
    chk("t4_hold_a", out_warp_id, 1);
    cyc(0, 0, 0, 4'h0, 0);
    chk("t4_hold_b", out_warp_id, 1);
    cyc(0, 0, 0, 4'h0, 1);
    chk("t4_next", out_warp_id, 0);

    // Flush of granted warp 1
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 1, 32'h400 + i, 4'h0, 0);
    in_valid = 1'b1; in_warp_id = 2'd1; flush_mask = 4'b0010;
    #1;
    chk("t5_valid", out_valid, 0);
    chk("t5_in_ready", in_ready, 0);
    cyc(1, 1, 32'h4FF, 4'b0010, 0);
    chk("t5_empty1", empty_mask[1], 1);

    // Entries in every warp, then reset mid-stream
    for (int w = 0; w < NW; w++) cyc(1, w, 32'h500 + w, 4'h0, 0);
    do_reset();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 4) != 0, int'($urandom_range(0, NW - 1)), $urandom,
          (($urandom % 16) == 0) ? 4'($urandom) : 4'h0, ($urandom % 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
